// File: rtl/ivs_ram_arb.sv
// ivs_ram_arb: two-requester round-robin arbiter in front of a single-port scratch RAM.
//
// Requester 0 (AHB register slave) and requester 1 (AXI DMA model) issue single-beat reads
// and writes over valid/ready. The winning request is copied onto the RAM strobes in the
// same cycle. Read data comes back one cycle later on the response port of the requester
// that issued the read. A requester may hold ownership across a short locked burst; after
// MAX_HOLD consecutive locked grants it must hand over.
//
// Ports:
//   hclk, hrst                 clock, asynchronous active-high reset
//   reqN_valid/ready           request handshake (ready is combinational)
//   reqN_write/lock/addr/wdata request fields
//   rspN_valid/rdata           read response (one-cycle pulse, rdata held between pulses)
//   ram_rd/we/addr/wdata       RAM strobes, zero when nothing is accepted
//   ram_rdata                  RAM read data, valid the cycle after ram_rd
module ivs_ram_arb #(
   parameter int unsigned DW       = 32,
   parameter int unsigned AW       = 6,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic          hclk,
   input  logic          hrst,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic          req0_write,
   input  logic          req0_lock,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_wdata,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic          req1_write,
   input  logic          req1_lock,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_wdata,
   output logic          rsp0_valid,
   output logic [DW-1:0] rsp0_rdata,
   output logic          rsp1_valid,
   output logic [DW-1:0] rsp1_rdata,
   output logic          ram_rd,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   localparam logic [4:0] MaxHold = 5'(MAX_HOLD);

   logic          last_grant_q, last_grant_d;
   logic          locked_q, locked_d;
   logic          owner_q, owner_d;
   logic [3:0]    hold_cnt_q, hold_cnt_d;
   logic          pend_q, pend_d;
   logic          pend_id_q, pend_id_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;

   logic          owner_valid;
   logic          gnt_valid;
   logic          gnt_id;
   logic          g_write;
   logic          g_lock;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] g_wdata;
   logic          owner_cont;
   logic [4:0]    hold_inc;

   // Arbitration decision and RAM strobes
   always_comb begin
      owner_valid = owner_q ? req1_valid : req0_valid;
      gnt_valid   = (req0_valid | req1_valid) & ~hrst;
      if (locked_q && owner_valid) begin
         gnt_id = owner_q;
      end else if (req0_valid && req1_valid) begin
         gnt_id = ~last_grant_q;
      end else begin
         // Single (or no) requester; a locked owner that went idle loses the grant here.
         gnt_id = req1_valid;
      end

      g_write = gnt_id ? req1_write : req0_write;
      g_lock  = gnt_id ? req1_lock  : req0_lock;
      g_addr  = gnt_id ? req1_addr  : req0_addr;
      g_wdata = gnt_id ? req1_wdata : req0_wdata;

      req0_ready = gnt_valid & ~gnt_id;
      req1_ready = gnt_valid &  gnt_id;
      ram_rd     = gnt_valid & ~g_write;
      ram_we     = gnt_valid &  g_write;
      ram_addr   = gnt_valid ? g_addr  : '0;
      ram_wdata  = gnt_valid ? g_wdata : '0;
   end

   // Next arbitration state and read-return tracking
   always_comb begin
      last_grant_d = last_grant_q;
      locked_d     = locked_q;
      owner_d      = owner_q;
      hold_cnt_d   = hold_cnt_q;
      owner_cont   = locked_q && (owner_q == gnt_id);
      hold_inc     = {1'b0, hold_cnt_q} + 5'd1;

      if (gnt_valid) begin
         last_grant_d = gnt_id;
         if (g_lock && (!owner_cont || hold_inc < MaxHold)) begin
            locked_d   = 1'b1;
            owner_d    = gnt_id;
            hold_cnt_d = owner_cont ? hold_inc[3:0] : 4'd1;
         end else begin
            // Hold limit reached: last_grant already points at the owner, so the
            // other requester wins the next contended cycle.
            locked_d   = 1'b0;
            hold_cnt_d = 4'd0;
         end
      end

      pend_d    = gnt_valid & ~g_write;
      pend_id_d = gnt_id;

      rsp0_valid = pend_q & ~pend_id_q;
      rsp1_valid = pend_q &  pend_id_q;
      rsp0_rdata = rsp0_valid ? ram_rdata : rdata0_q;
      rsp1_rdata = rsp1_valid ? ram_rdata : rdata1_q;
      rdata0_d   = rsp0_rdata;
      rdata1_d   = rsp1_rdata;
   end

   always_ff @(posedge hclk or posedge hrst) begin
      if (hrst) begin
         last_grant_q <= 1'b1;
         locked_q     <= 1'b0;
         owner_q      <= 1'b0;
         hold_cnt_q   <= 4'd0;
         pend_q       <= 1'b0;
         pend_id_q    <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         locked_q     <= locked_d;
         owner_q      <= owner_d;
         hold_cnt_q   <= hold_cnt_d;
         pend_q       <= pend_d;
         pend_id_q    <= pend_id_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

endmodule
